// File: rtl/issue_rfread_stage_pkg.sv
// Shared core types for the issue/regfile-read stage: operand width, register
// index types, the execution payload and the read-port map built by the allocator.
package issue_rfread_stage_pkg;

  localparam int NUMSRCS_INT    = 2;
  localparam int RFREAD_NUM_DEF = 3;
  localparam int XLEN           = 64;
  localparam int IPR_W          = 6;
  localparam int ROB_W          = 5;
  localparam int RFPORT_IDX_W   = 4;
  localparam int CNT_W          = RFPORT_IDX_W + 1;

  typedef logic [IPR_W-1:0]        iprIdx_t;
  typedef logic [ROB_W-1:0]        robIdx_t;
  typedef logic [XLEN-1:0]         opData_t;
  typedef logic [CNT_W-1:0]        rfCnt_t;
  typedef logic [RFPORT_IDX_W-1:0] rfPort_t;

  typedef struct packed {
    iprIdx_t [NUMSRCS_INT-1:0] iprs_idx;
    iprIdx_t                   iprd_idx;
    logic                      rd_wen;
    robIdx_t                   rob_idx;
  } exeInfo_t;

  // Per issue port: which read port serves each source, and whether the port won.
  typedef struct packed {
    logic                      granted;
    rfPort_t [NUMSRCS_INT-1:0] port;
  } rfPortMap_t;

  // Sources reading physical register 0 are hardwired zero and need no read port.
  function automatic rfCnt_t src_need(input iprIdx_t [NUMSRCS_INT-1:0] iprs);
    rfCnt_t n;
    n = '0;
    for (int s = 0; s < NUMSRCS_INT; s++) begin
      if (iprs[s] != '0) begin
        n = n + rfCnt_t'(1);
      end else begin
        n = n;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/issue_rfread_stage_rfport_alloc.sv
// Combinational first-fit allocator of physical regfile read ports to issue ports.
// A port is granted only if every non-zero source fits; later ports still try.
module issue_rfread_stage_rfport_alloc
  import issue_rfread_stage_pkg::*;
#(
  parameter int PORTS      = 2,
  parameter int RFREAD_NUM = RFREAD_NUM_DEF
) (
  input  logic [PORTS-1:0]                         can_issue,
  input  iprIdx_t [PORTS-1:0][NUMSRCS_INT-1:0]     iprs_idx,
  output rfPortMap_t [PORTS-1:0]                   port_map,
  output logic [RFREAD_NUM-1:0]                    rd_vld,
  output iprIdx_t [RFREAD_NUM-1:0]                 rd_idx
);

  // Scan issue ports in order, handing out read ports lowest-first.
  always_comb begin
    rfCnt_t used;
    rfCnt_t need;
    used     = '0;
    need     = '0;
    port_map = '0;
    rd_vld   = '0;
    rd_idx   = '0;
    for (int p = 0; p < PORTS; p++) begin
      need = src_need(iprs_idx[p]);
      if (can_issue[p] && ((used + need) <= rfCnt_t'(RFREAD_NUM))) begin
        port_map[p].granted = 1'b1;
        for (int s = 0; s < NUMSRCS_INT; s++) begin
          if (iprs_idx[p][s] != '0) begin
            port_map[p].port[s] = used[RFPORT_IDX_W-1:0];
            for (int r = 0; r < RFREAD_NUM; r++) begin
              if (used == rfCnt_t'(r)) begin
                rd_vld[r] = 1'b1;
                rd_idx[r] = iprs_idx[p][s];
              end else begin
                rd_vld[r] = rd_vld[r];
              end
            end
            used = used + rfCnt_t'(1);
          end else begin
            used = used;
          end
        end
      end else begin
        used = used;
      end
    end
  end

endmodule

// File: rtl/issue_rfread_stage.sv
// Issue-queue consumer: allocates regfile read ports, checks speculative-wakeup
// cancels, returns finished/replay feedback and drives a backpressured FU bundle.
module issue_rfread_stage
  import issue_rfread_stage_pkg::*;
#(
  parameter int DEPTH         = 8,
  parameter int INOUTPORT_NUM = 2,
  parameter int RFREAD_NUM    = RFREAD_NUM_DEF,
  parameter int CANCEL_NUM    = 2,
  parameter bit SINGLEEXE     = 1'b0
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic [INOUTPORT_NUM-1:0]                              i_can_issue,
  input  logic [INOUTPORT_NUM-1:0][$clog2(DEPTH)-1:0]           i_issue_idx,
  input  exeInfo_t [INOUTPORT_NUM-1:0]                          i_issue_exeInfo,
  output logic                                                  o_stall,
  output logic [INOUTPORT_NUM-1:0]                              o_issue_finished_vec,
  output logic [INOUTPORT_NUM-1:0]                              o_issue_replay_vec,
  output logic [INOUTPORT_NUM-1:0][$clog2(DEPTH)-1:0]           o_feedback_idx,
  output logic [RFREAD_NUM-1:0]                                 o_rf_rd_vld,
  output iprIdx_t [RFREAD_NUM-1:0]                              o_rf_rd_idx,
  input  opData_t [RFREAD_NUM-1:0]                              i_rf_rd_data,
  input  logic [CANCEL_NUM-1:0]                                 i_cancel_vld,
  input  iprIdx_t [CANCEL_NUM-1:0]                              i_cancel_rdIdx,
  output logic [INOUTPORT_NUM-1:0]                              o_fu_vld,
  output exeInfo_t [INOUTPORT_NUM-1:0]                          o_fu_exeInfo,
  output opData_t [INOUTPORT_NUM-1:0][NUMSRCS_INT-1:0]          o_fu_srcdata,
  input  logic                                                  i_fu_ready
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [INOUTPORT_NUM-1:0]                        alloc_req;
  iprIdx_t [INOUTPORT_NUM-1:0][NUMSRCS_INT-1:0]    alloc_iprs;
  rfPortMap_t [INOUTPORT_NUM-1:0]                  alloc_map;
  logic [RFREAD_NUM-1:0]                           alloc_rd_vld;
  iprIdx_t [RFREAD_NUM-1:0]                        alloc_rd_idx;

  logic [INOUTPORT_NUM-1:0]                        s1_vld_q, s1_vld_d;
  logic [INOUTPORT_NUM-1:0][IDX_W-1:0]             s1_idx_q, s1_idx_d;
  exeInfo_t [INOUTPORT_NUM-1:0]                    s1_info_q, s1_info_d;
  rfPortMap_t [INOUTPORT_NUM-1:0]                  s1_map_q, s1_map_d;
  opData_t [INOUTPORT_NUM-1:0][NUMSRCS_INT-1:0]    s1_data_q, s1_data_d;
  logic                                            s1_held_q, s1_held_d;

  logic [INOUTPORT_NUM-1:0]                        fu_vld_q, fu_vld_d;
  exeInfo_t [INOUTPORT_NUM-1:0]                    fu_info_q, fu_info_d;
  opData_t [INOUTPORT_NUM-1:0][NUMSRCS_INT-1:0]    fu_src_q, fu_src_d;

  opData_t [INOUTPORT_NUM-1:0][NUMSRCS_INT-1:0]    t2_src;
  logic [INOUTPORT_NUM-1:0]                        cancel_hit;
  logic [INOUTPORT_NUM-1:0]                        finished;
  logic [INOUTPORT_NUM-1:0]                        replay;

  assign o_stall   = (|fu_vld_q) & ~i_fu_ready;
  assign alloc_req = i_can_issue & {INOUTPORT_NUM{~o_stall}};

  for (genvar gp = 0; gp < INOUTPORT_NUM; gp++) begin : g_iprs
    assign alloc_iprs[gp] = i_issue_exeInfo[gp].iprs_idx;
  end

  issue_rfread_stage_rfport_alloc #(
    .PORTS      (INOUTPORT_NUM),
    .RFREAD_NUM (RFREAD_NUM)
  ) u_alloc (
    .can_issue (alloc_req),
    .iprs_idx  (alloc_iprs),
    .port_map  (alloc_map),
    .rd_vld    (alloc_rd_vld),
    .rd_idx    (alloc_rd_idx)
  );

  // Read requests are suppressed while reset is asserted, not only once flops clear.
  assign o_rf_rd_vld = alloc_rd_vld & {RFREAD_NUM{~rst}};
  assign o_rf_rd_idx = alloc_rd_idx;

  // T2 operands: zero for x0, the held copy once stalled, else live read data.
  always_comb begin
    t2_src = '0;
    for (int p = 0; p < INOUTPORT_NUM; p++) begin
      for (int s = 0; s < NUMSRCS_INT; s++) begin
        if (s1_info_q[p].iprs_idx[s] == '0) begin
          t2_src[p][s] = '0;
        end else if (s1_held_q) begin
          t2_src[p][s] = s1_data_q[p][s];
        end else begin
          for (int r = 0; r < RFREAD_NUM; r++) begin
            if (s1_map_q[p].port[s] == rfPort_t'(r)) begin
              t2_src[p][s] = i_rf_rd_data[r];
            end else begin
              t2_src[p][s] = t2_src[p][s];
            end
          end
        end
      end
    end
  end

  // Cancel check is re-evaluated every T2 cycle, including stalled ones.
  always_comb begin
    cancel_hit = '0;
    for (int p = 0; p < INOUTPORT_NUM; p++) begin
      for (int c = 0; c < CANCEL_NUM; c++) begin
        for (int s = 0; s < NUMSRCS_INT; s++) begin
          if (!SINGLEEXE && i_cancel_vld[c] &&
              (i_cancel_rdIdx[c] == s1_info_q[p].iprs_idx[s])) begin
            cancel_hit[p] = 1'b1;
          end else begin
            cancel_hit[p] = cancel_hit[p];
          end
        end
      end
    end
  end

  // Feedback fires only on a non-stalled T2 cycle.
  always_comb begin
    finished = '0;
    replay   = '0;
    for (int p = 0; p < INOUTPORT_NUM; p++) begin
      if (!o_stall && s1_vld_q[p]) begin
        finished[p] = s1_map_q[p].granted & ~cancel_hit[p];
        replay[p]   = SINGLEEXE ? 1'b0 : (~s1_map_q[p].granted | cancel_hit[p]);
      end else begin
        finished[p] = 1'b0;
        replay[p]   = 1'b0;
      end
    end
  end

  assign o_issue_finished_vec = finished;
  assign o_issue_replay_vec   = replay;
  assign o_feedback_idx       = s1_idx_q;

  // S1 advances when unstalled; on the first stalled cycle it captures the read data.
  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_idx_d  = s1_idx_q;
    s1_info_d = s1_info_q;
    s1_map_d  = s1_map_q;
    s1_data_d = s1_data_q;
    s1_held_d = s1_held_q;
    if (!o_stall) begin
      s1_vld_d  = i_can_issue;
      s1_idx_d  = i_issue_idx;
      s1_info_d = i_issue_exeInfo;
      s1_map_d  = alloc_map;
      s1_held_d = 1'b0;
    end else if (!s1_held_q) begin
      s1_data_d = t2_src;
      s1_held_d = 1'b1;
    end else begin
      s1_held_d = 1'b1;
    end
  end

  // FU bundle loads finished entries when unstalled and holds otherwise.
  always_comb begin
    fu_vld_d  = fu_vld_q;
    fu_info_d = fu_info_q;
    fu_src_d  = fu_src_q;
    if (!o_stall) begin
      fu_vld_d  = finished;
      fu_info_d = s1_info_q;
      fu_src_d  = t2_src;
    end else begin
      fu_vld_d  = fu_vld_q;
    end
  end

  // Pipeline state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q  <= '0;
      s1_idx_q  <= '0;
      s1_info_q <= '0;
      s1_map_q  <= '0;
      s1_data_q <= '0;
      s1_held_q <= 1'b0;
      fu_vld_q  <= '0;
      fu_info_q <= '0;
      fu_src_q  <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_idx_q  <= s1_idx_d;
      s1_info_q <= s1_info_d;
      s1_map_q  <= s1_map_d;
      s1_data_q <= s1_data_d;
      s1_held_q <= s1_held_d;
      fu_vld_q  <= fu_vld_d;
      fu_info_q <= fu_info_d;
      fu_src_q  <= fu_src_d;
    end
  end

  assign o_fu_vld     = fu_vld_q;
  assign o_fu_exeInfo = fu_info_q;
  assign o_fu_srcdata = fu_src_q;

  if (SINGLEEXE) begin : g_single_exe_chk
    logic [INOUTPORT_NUM-1:0] s1_gnt;
    for (genvar gp = 0; gp < INOUTPORT_NUM; gp++) begin : g_gnt
      assign s1_gnt[gp] = s1_map_q[gp].granted;
    end
    a_no_ungranted: assert property (@(posedge clk) disable iff (rst)
      ((s1_vld_q & ~s1_gnt) == '0));
  end

endmodule

// File: tb/tb_issue_rfread_stage.sv
// Directed bench for issue_rfread_stage with a transaction-level reference model
// checked every cycle, plus hand-computed literal checks for each scenario.
module tb_issue_rfread_stage;
  import issue_rfread_stage_pkg::*;

  logic                      clk;
  logic                      rst;
  logic [1:0]                i_can_issue;
  logic [1:0][2:0]           i_issue_idx;
  exeInfo_t [1:0]            i_issue_exeInfo;
  logic                      o_stall;
  logic [1:0]                o_issue_finished_vec;
  logic [1:0]                o_issue_replay_vec;
  logic [1:0][2:0]           o_feedback_idx;
  logic [2:0]                o_rf_rd_vld;
  iprIdx_t [2:0]             o_rf_rd_idx;
  opData_t [2:0]             i_rf_rd_data;
  logic [1:0]                i_cancel_vld;
  iprIdx_t [1:0]             i_cancel_rdIdx;
  logic [1:0]                o_fu_vld;
  exeInfo_t [1:0]            o_fu_exeInfo;
  opData_t [1:0][1:0]        o_fu_srcdata;
  logic                      i_fu_ready;

  int n_cmp = 0;
  int n_bad = 0;

  issue_rfread_stage #(
    .DEPTH(8), .INOUTPORT_NUM(2), .RFREAD_NUM(3), .CANCEL_NUM(2), .SINGLEEXE(1'b0)
  ) dut (
    .clk(clk), .rst(rst),
    .i_can_issue(i_can_issue), .i_issue_idx(i_issue_idx), .i_issue_exeInfo(i_issue_exeInfo),
    .o_stall(o_stall),
    .o_issue_finished_vec(o_issue_finished_vec), .o_issue_replay_vec(o_issue_replay_vec),
    .o_feedback_idx(o_feedback_idx),
    .o_rf_rd_vld(o_rf_rd_vld), .o_rf_rd_idx(o_rf_rd_idx), .i_rf_rd_data(i_rf_rd_data),
    .i_cancel_vld(i_cancel_vld), .i_cancel_rdIdx(i_cancel_rdIdx),
    .o_fu_vld(o_fu_vld), .o_fu_exeInfo(o_fu_exeInfo), .o_fu_srcdata(o_fu_srcdata),
    .i_fu_ready(i_fu_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic opData_t rf_val(input iprIdx_t i);
    return 64'h1111_0000_0000_0000 | {58'd0, i};
  endfunction

  function automatic exeInfo_t mk(input iprIdx_t a, input iprIdx_t b);
    exeInfo_t e;
    e.iprs_idx[0] = a;
    e.iprs_idx[1] = b;
    e.iprd_idx    = a + b + 6'd1;
    e.rd_wen      = 1'b1;
    e.rob_idx     = a[4:0] ^ b[4:0];
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Regfile responder: data for a request appears during the following cycle.
  logic [2:0]    rq_vld = 3'b000;
  iprIdx_t [2:0] rq_idx;
  always @(negedge clk) begin
    rq_vld = o_rf_rd_vld;
    rq_idx = o_rf_rd_idx;
  end
  always @(posedge clk) begin
    #1;
    for (int r = 0; r < 3; r++)
      i_rf_rd_data[r] = rq_vld[r] ? rf_val(rq_idx[r]) : {$urandom, $urandom};
  end

  // Reference model state: the accepted presentation awaiting feedback, and the FU bundle.
  logic [1:0]         m_pend_vld, m_pend_gnt, m_fu_vld;
  logic [1:0][2:0]    m_pend_idx;
  exeInfo_t [1:0]     m_pend_info, m_fu_info;
  opData_t [1:0][1:0] m_fu_src;

  initial begin
    m_pend_vld = '0; m_pend_gnt = '0; m_fu_vld = '0;
    m_pend_idx = '0; m_pend_info = '0; m_fu_info = '0; m_fu_src = '0;
  end

  always @(negedge clk) begin : cmp
    logic       exp_stall;
    logic [1:0] exp_fin, exp_rep, gnt;
    logic [2:0] exp_rvld;
    iprIdx_t    exp_ridx [3];
    int         free, k, need;
    logic       hit;
    if (rst) begin
      m_pend_vld = '0;
      m_fu_vld   = '0;
    end
    exp_stall = (|m_fu_vld) && !i_fu_ready;
    exp_fin = '0; exp_rep = '0; gnt = '0; exp_rvld = '0;
    for (int r = 0; r < 3; r++) exp_ridx[r] = '0;
    for (int p = 0; p < 2; p++) begin
      hit = 1'b0;
      for (int c = 0; c < 2; c++)
        for (int s = 0; s < 2; s++)
          if (i_cancel_vld[c] && i_cancel_rdIdx[c] == m_pend_info[p].iprs_idx[s]) hit = 1'b1;
      if (!exp_stall && m_pend_vld[p]) begin
        exp_fin[p] = m_pend_gnt[p] && !hit;
        exp_rep[p] = !m_pend_gnt[p] || hit;
      end
    end
    if (!rst && !exp_stall) begin
      free = 3; k = 0;
      for (int p = 0; p < 2; p++) begin
        need = 0;
        for (int s = 0; s < 2; s++) if (i_issue_exeInfo[p].iprs_idx[s] != 0) need++;
        if (i_can_issue[p] && need <= free) begin
          gnt[p] = 1'b1;
          free   = free - need;
          for (int s = 0; s < 2; s++)
            if (i_issue_exeInfo[p].iprs_idx[s] != 0) begin
              exp_rvld[k] = 1'b1;
              exp_ridx[k] = i_issue_exeInfo[p].iprs_idx[s];
              k++;
            end
        end
      end
    end
    chk("stall", o_stall, exp_stall);
    chk("finished", o_issue_finished_vec, exp_fin);
    chk("replay", o_issue_replay_vec, exp_rep);
    for (int p = 0; p < 2; p++)
      if (exp_fin[p] || exp_rep[p]) chk("fb_idx", o_feedback_idx[p], m_pend_idx[p]);
    chk("rd_vld", o_rf_rd_vld, exp_rvld);
    for (int r = 0; r < 3; r++)
      if (exp_rvld[r]) chk("rd_idx", o_rf_rd_idx[r], exp_ridx[r]);
    chk("fu_vld", o_fu_vld, m_fu_vld);
    for (int p = 0; p < 2; p++)
      if (m_fu_vld[p]) begin
        chk("fu_info", 64'(o_fu_exeInfo[p]), 64'(m_fu_info[p]));
        for (int s = 0; s < 2; s++) chk("fu_src", o_fu_srcdata[p][s], m_fu_src[p][s]);
      end
    if (!rst && !exp_stall) begin
      m_fu_vld  = exp_fin;
      m_fu_info = m_pend_info;
      for (int p = 0; p < 2; p++)
        for (int s = 0; s < 2; s++)
          m_fu_src[p][s] = (m_pend_info[p].iprs_idx[s] == 0) ? 64'd0 : rf_val(m_pend_info[p].iprs_idx[s]);
      m_pend_vld  = i_can_issue;
      m_pend_idx  = i_issue_idx;
      m_pend_info = i_issue_exeInfo;
      m_pend_gnt  = gnt;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_can_issue  = 2'b00;
    i_cancel_vld = 2'b00;
  endtask

  initial begin
    rst = 1'b1;
    i_fu_ready = 1'b1;
    i_cancel_vld = 2'b00;
    i_cancel_rdIdx = '0;
    i_can_issue = 2'b11;
    i_issue_idx[0] = 3'd1; i_issue_exeInfo[0] = mk(6'd1, 6'd2);
    i_issue_idx[1] = 3'd2; i_issue_exeInfo[1] = mk(6'd3, 6'd4);
    @(negedge clk);
    chk("rst_stall", o_stall, 1'b0);
    chk("rst_rd_vld", o_rf_rd_vld, 3'b000);
    chk("rst_fu_vld", o_fu_vld, 2'b00);
    chk("rst_fin", o_issue_finished_vec, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0;
    idle();
    step();

    // Both ports need two read ports; only port 0 fits.
    i_can_issue = 2'b11;
    i_issue_idx[0] = 3'd1; i_issue_exeInfo[0] = mk(6'd1, 6'd2);
    i_issue_idx[1] = 3'd3; i_issue_exeInfo[1] = mk(6'd3, 6'd4);
    @(negedge clk);
    chk("t1_rd_vld", o_rf_rd_vld, 3'b011);
    chk("t1_rd_idx0", o_rf_rd_idx[0], 6'd1);
    chk("t1_rd_idx1", o_rf_rd_idx[1], 6'd2);
    step(); idle();
    @(negedge clk);
    chk("t1_fin", o_issue_finished_vec, 2'b01);
    chk("t1_rep", o_issue_replay_vec, 2'b10);
    chk("t1_fbidx1", o_feedback_idx[1], 3'd3);
    step();
    @(negedge clk);
    chk("t1_fu_vld", o_fu_vld, 2'b01);
    chk("t1_src01", o_fu_srcdata[0][1], 64'h1111_0000_0000_0002);
    step();

    // x0 source frees a read port so both ports fit.
    i_can_issue = 2'b11;
    i_issue_idx[0] = 3'd4; i_issue_exeInfo[0] = mk(6'd3, 6'd4);
    i_issue_idx[1] = 3'd5; i_issue_exeInfo[1] = mk(6'd0, 6'd5);
    @(negedge clk);
    chk("t2_rd_vld", o_rf_rd_vld, 3'b111);
    chk("t2_rd_idx2", o_rf_rd_idx[2], 6'd5);
    step(); idle();
    @(negedge clk);
    chk("t2_fin", o_issue_finished_vec, 2'b11);
    step();
    @(negedge clk);
    chk("t2_fu_vld", o_fu_vld, 2'b11);
    chk("t2_src10", o_fu_srcdata[1][0], 64'd0);
    chk("t2_src11", o_fu_srcdata[1][1], 64'h1111_0000_0000_0005);
    step();

    // Cancel of a source register in T2 turns a grant into a replay.
    i_can_issue = 2'b01;
    i_issue_idx[0] = 3'd6; i_issue_exeInfo[0] = mk(6'd7, 6'd9);
    step(); idle();
    i_cancel_vld = 2'b01; i_cancel_rdIdx[0] = 6'd9;
    @(negedge clk);
    chk("t3_rep", o_issue_replay_vec, 2'b01);
    chk("t3_fin", o_issue_finished_vec, 2'b00);
    chk("t3_fbidx0", o_feedback_idx[0], 3'd6);
    step(); idle();
    @(negedge clk);
    chk("t3_fu_vld", o_fu_vld, 2'b00);
    step();

    // FU backpressure: held data survives garbage read data, stalled presentation dropped.
    i_can_issue = 2'b01;
    i_issue_idx[0] = 3'd1; i_issue_exeInfo[0] = mk(6'd10, 6'd11);
    step();
    i_issue_idx[0] = 3'd7; i_issue_exeInfo[0] = mk(6'd12, 6'd0);
    @(negedge clk);
    chk("t4_fin_b", o_issue_finished_vec, 2'b01);
    step(); idle(); i_fu_ready = 1'b0;
    @(negedge clk);
    chk("t4_stall", o_stall, 1'b1);
    chk("t4_fu_vld", o_fu_vld, 2'b01);
    chk("t4_fin_s", o_issue_finished_vec, 2'b00);
    step();
    i_can_issue = 2'b10;
    i_issue_idx[1] = 3'd2; i_issue_exeInfo[1] = mk(6'd13, 6'd14);
    @(negedge clk);
    chk("t5_stall", o_stall, 1'b1);
    chk("t5_rd_vld", o_rf_rd_vld, 3'b000);
    chk("t5_rep", o_issue_replay_vec, 2'b00);
    step(); idle();
    @(negedge clk);
    chk("t4_stall3", o_stall, 1'b1);
    step(); i_fu_ready = 1'b1;
    @(negedge clk);
    chk("t4_fin_c", o_issue_finished_vec, 2'b01);
    chk("t4_fbidx0", o_feedback_idx[0], 3'd7);
    chk("t4_rep_c", o_issue_replay_vec, 2'b00);
    step();
    @(negedge clk);
    chk("t4_fu_vld_c", o_fu_vld, 2'b01);
    chk("t4_src00", o_fu_srcdata[0][0], 64'h1111_0000_0000_000C);
    chk("t4_src01", o_fu_srcdata[0][1], 64'd0);
    chk("t5_nofb", o_issue_finished_vec | o_issue_replay_vec, 2'b00);
    step();
    @(negedge clk);
    chk("t5_nofb2", o_issue_finished_vec | o_issue_replay_vec, 2'b00);
    step();

    // Asynchronous reset while stalled with a valid FU bundle and a full S1.
    i_can_issue = 2'b01;
    i_issue_idx[0] = 3'd3; i_issue_exeInfo[0] = mk(6'd1, 6'd2);
    step();
    i_can_issue = 2'b10;
    i_issue_idx[1] = 3'd4; i_issue_exeInfo[1] = mk(6'd5, 6'd6);
    @(negedge clk);
    chk("t6_fin_d", o_issue_finished_vec, 2'b01);
    step(); idle(); i_fu_ready = 1'b0;
    @(negedge clk);
    chk("t6_stall", o_stall, 1'b1);
    #2;
    i_can_issue = 2'b01;
    rst = 1'b1;
    #1;
    chk("t6_rst_stall", o_stall, 1'b0);
    chk("t6_rst_fu_vld", o_fu_vld, 2'b00);
    chk("t6_rst_fb", o_issue_finished_vec | o_issue_replay_vec, 2'b00);
    chk("t6_rst_rd_vld", o_rf_rd_vld, 3'b000);
    step();
    step();
    rst = 1'b0; idle(); i_fu_ready = 1'b1;
    step();
    i_can_issue = 2'b01;
    i_issue_idx[0] = 3'd5; i_issue_exeInfo[0] = mk(6'd3, 6'd0);
    @(negedge clk);
    chk("t6_rd_vld", o_rf_rd_vld, 3'b001);
    step(); idle();
    @(negedge clk);
    chk("t6_fin_f", o_issue_finished_vec, 2'b01);
    chk("t6_fbidx0", o_feedback_idx[0], 3'd5);
    chk("t6_rep_f", o_issue_replay_vec, 2'b00);
    step();
    @(negedge clk);
    chk("t6_fu_vld_f", o_fu_vld, 2'b01);
    chk("t6_src00", o_fu_srcdata[0][0], 64'h1111_0000_0000_0003);
    step();
    step();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
